// File: rtl/i2s_tx2.sv
// Two-channel I2S serialiser: one stereo pair per 64-bit frame, MSB first,
// ws/sd driven from the falling edge of sck so a rising-edge receiver samples stable data.
//
// Handshake: a pair transfers on the falling sck edge where in_valid and in_ready are
// both high; in_ready is simply "holding register empty" and never depends on in_valid.
module i2s_tx2 #(
   parameter int N = 32
) (
   input  logic         sck,
   input  logic         nrst,
   input  logic         en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_chan0,
   input  logic [N-1:0] in_chan1,
   output logic         ws,
   output logic         sd,
   output logic [7:0]   underruns
);

   localparam int PAD = 32 - N;
   localparam logic [5:0] LAST_BIT = 6'd63;
   localparam logic [5:0] WS_RISE  = 6'd31;

   logic [N-1:0] hold_chan0;
   logic [N-1:0] hold_chan1;
   logic         hold_full;
   logic         hold_full_nxt;
   logic [5:0]   cnt;
   logic [5:0]   cnt_nxt;
   logic [63:0]  shreg;
   logic [63:0]  shreg_nxt;
   logic [31:0]  slot0;
   logic [31:0]  slot1;
   logic         accept;
   logic         ws_nxt;
   logic         sd_nxt;
   logic [7:0]   underruns_nxt;

   assign in_ready = !hold_full;
   assign accept   = in_valid && in_ready;

   // Samples narrower than the 32-bit slot are left-justified, pad bits trail the LSB.
   assign slot0 = 32'(hold_chan0) << PAD;
   assign slot1 = 32'(hold_chan1) << PAD;

   always_comb begin
      cnt_nxt       = cnt;
      shreg_nxt     = shreg;
      hold_full_nxt = hold_full;
      underruns_nxt = underruns;
      ws_nxt        = 1'b0;
      sd_nxt        = 1'b0;

      if (cnt != LAST_BIT) begin
         cnt_nxt   = cnt + 6'd1;
         shreg_nxt = {shreg[62:0], 1'b0};
      end else if (en) begin
         cnt_nxt = 6'd0;
         if (hold_full) begin
            shreg_nxt     = {slot0, slot1};
            hold_full_nxt = 1'b0;
         end else begin
            shreg_nxt = '0;
            if (underruns != 8'hFF) begin
               underruns_nxt = underruns + 8'd1;
            end
         end
      end else begin
         shreg_nxt = '0;
      end

      // An accept on the load edge only happens when the register was already empty,
      // so it never collides with the clear above.
      if (accept) begin
         hold_full_nxt = 1'b1;
      end

      // ws leads each slot's MSB by one bit period; idle (cnt stays 63) gives ws=0, sd=0.
      sd_nxt = shreg_nxt[63];
      ws_nxt = (cnt_nxt >= WS_RISE) && (cnt_nxt != LAST_BIT);
   end

   always_ff @(negedge sck or negedge nrst) begin
      if (!nrst) begin
         cnt        <= LAST_BIT;
         shreg      <= '0;
         ws         <= 1'b0;
         sd         <= 1'b0;
         hold_full  <= 1'b0;
         hold_chan0 <= '0;
         hold_chan1 <= '0;
         underruns  <= '0;
      end else begin
         cnt       <= cnt_nxt;
         shreg     <= shreg_nxt;
         ws        <= ws_nxt;
         sd        <= sd_nxt;
         hold_full <= hold_full_nxt;
         underruns <= underruns_nxt;
         if (accept) begin
            hold_chan0 <= in_chan0;
            hold_chan1 <= in_chan1;
         end
      end
   end

endmodule
